// File: rtl/attribute_group_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : attribute_group_arbiter
// Purpose  : Shares one registered attribute-result output among DATA_GROUPS
//            producers. Each producer fills a one-word holding register via
//            valid/ready; a fixed-priority or round-robin scheduler moves one
//            held word per cycle into a backpressured output stage.
// Revision : 1.0 - initial release
// ============================================================================
module attribute_group_arbiter #(
    parameter int ATTRIBUTE_DATA_WIDTH = 135,
    parameter int DATA_GROUPS          = 4,
    parameter int GROUP_SEL_WIDTH      = 2
) (
    input  logic                                        clk,
    input  logic                                        resetn,
    input  logic                                        priority_mode,
    input  logic [DATA_GROUPS-1:0]                      in_valid,
    output logic [DATA_GROUPS-1:0]                      in_ready,
    input  logic [DATA_GROUPS*ATTRIBUTE_DATA_WIDTH-1:0] in_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [ATTRIBUTE_DATA_WIDTH-1:0]             out_data,
    output logic [GROUP_SEL_WIDTH-1:0]                  out_group
);

    // Reset value of last_grant: makes the first round-robin search begin at 0.
    localparam logic [GROUP_SEL_WIDTH-1:0] c_LAST_GROUP = GROUP_SEL_WIDTH'(DATA_GROUPS - 1);

    logic [DATA_GROUPS-1:0]          r_hold_valid;
    logic [ATTRIBUTE_DATA_WIDTH-1:0] r_hold_data [DATA_GROUPS];
    logic                            r_out_valid;
    logic [ATTRIBUTE_DATA_WIDTH-1:0] r_out_data;
    logic [GROUP_SEL_WIDTH-1:0]      r_out_group;
    logic [GROUP_SEL_WIDTH-1:0]      r_last_grant;

    logic                            w_load_en;
    logic                            w_any_pending;
    logic                            w_grant;
    logic [GROUP_SEL_WIDTH-1:0]      w_winner;

    // Highest pending index wins.
    function automatic logic [GROUP_SEL_WIDTH-1:0] f_fixed_pick(
        input logic [DATA_GROUPS-1:0] req
    );
        f_fixed_pick = '0;
        for (int i = 0; i < DATA_GROUPS; i++) begin
            if (req[i]) begin
                f_fixed_pick = GROUP_SEL_WIDTH'(i);
            end
        end
    endfunction

    // First pending index after 'last', wrapping; 'last' itself is tried last.
    // Scanning from the farthest offset down lets the nearest hit overwrite.
    function automatic logic [GROUP_SEL_WIDTH-1:0] f_rr_pick(
        input logic [DATA_GROUPS-1:0]     req,
        input logic [GROUP_SEL_WIDTH-1:0] last
    );
        int                         idx;
        logic [GROUP_SEL_WIDTH-1:0] sel;
        f_rr_pick = last;
        for (int k = DATA_GROUPS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= DATA_GROUPS) begin
                idx = idx - DATA_GROUPS;
            end
            sel = GROUP_SEL_WIDTH'(idx);
            if (req[sel]) begin
                f_rr_pick = sel;
            end
        end
    endfunction

    assign w_load_en     = ~r_out_valid | out_ready;
    assign w_any_pending = |r_hold_valid;
    assign w_grant       = w_load_en & w_any_pending;
    assign w_winner      = priority_mode ? f_rr_pick(r_hold_valid, r_last_grant)
                                         : f_fixed_pick(r_hold_valid);

    // Holding registers: a grant frees a slot, an empty slot captures its input.
    // Grant and capture never coincide because a grant needs the slot full.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hold_valid <= '0;
            for (int i = 0; i < DATA_GROUPS; i++) begin
                r_hold_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DATA_GROUPS; i++) begin
                if (w_grant && (w_winner == GROUP_SEL_WIDTH'(i))) begin
                    r_hold_valid[i] <= 1'b0;
                end else if (in_valid[i] && !r_hold_valid[i]) begin
                    r_hold_valid[i] <= 1'b1;
                    r_hold_data[i]  <= in_data[i*ATTRIBUTE_DATA_WIDTH +: ATTRIBUTE_DATA_WIDTH];
                end
            end
        end
    end

    // Output stage: loads the winner when free or being drained, else holds.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_group  <= '0;
            r_last_grant <= c_LAST_GROUP;
        end else if (w_load_en) begin
            r_out_valid <= w_any_pending;
            if (w_any_pending) begin
                r_out_data   <= r_hold_data[w_winner];
                r_out_group  <= w_winner;
                r_last_grant <= w_winner;
            end
        end
    end

    // Ready is purely the slot-empty flag, with no path from out_ready.
    assign in_ready  = ~r_hold_valid;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_group = r_out_group;

endmodule
`default_nettype wire

// File: doc/attribute_group_arbiter.md
Name: attribute_group_arbiter

Overview:
- Shares a single attribute-result output channel among DATA_GROUPS parallel lookup/attribute producers in the packet analyzer.
- Each producer hands one result to a per-group holding register using a valid/ready handshake.
- A scheduler picks one pending group per cycle, using either fixed priority or round-robin, and loads the winner into a registered output stage with valid/ready backpressure.
- It replaces purely combinational priority selection wherever downstream can stall or fairness is required.

Parameters:
- ATTRIBUTE_DATA_WIDTH, 135: width of one result word.
- DATA_GROUPS, 4: number of requesters; legal range 2..16.
- GROUP_SEL_WIDTH, 2: width of out_group; must equal ceil(log2(DATA_GROUPS)).

Ports:
- clk  in  1  block clock; all state updates on its rising edge.
- resetn  in  1  reset, asynchronous and active-low.
- priority_mode  in  1  0 = fixed priority (highest index wins), 1 = round-robin; sampled every cycle.
- in_valid  in  DATA_GROUPS  per-group result valid.
- in_ready  out  DATA_GROUPS  per-group holding register empty.
- in_data  in  DATA_GROUPS*ATTRIBUTE_DATA_WIDTH  group i occupies bits [i*W+W-1 : i*W].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_data  out  ATTRIBUTE_DATA_WIDTH  selected result.
- out_group  out  GROUP_SEL_WIDTH  index of the group that produced out_data.

Behaviour:
- Reset (resetn=0, asynchronous) clears:
  - hold_valid[*] to 0, so in_ready is all ones.
  - out_valid, out_data and out_group to 0.
  - last_grant to DATA_GROUPS-1, so the first round-robin search starts at group 0.
- Reset mid-operation discards all held and output words; nothing is replayed.
- in_ready[i] = ~hold_valid[i]. It is a direct register output with no combinational path from out_ready or from other groups.
- Capture: when in_valid[i] & in_ready[i] on a clock edge, hold_data[i] <= in_data slice and hold_valid[i] <= 1.
- A group whose register was freed by a grant is not ready until the next cycle, so per-group throughput is at most 1 word per 2 cycles.
- Aggregate throughput is 1 word per cycle when two or more groups are pending.
- load_en = ~out_valid | out_ready.
- Grant: when load_en and any hold_valid is set, select the winner w:
  - Mode 0: highest set index.
  - Mode 1: first set index found searching last_grant+1, last_grant+2, ... with wrap from DATA_GROUPS-1 to 0; last_grant itself is searched last.
- On grant, at the same edge:
  - out_valid <= 1, out_data <= hold_data[w], out_group <= w.
  - hold_valid[w] <= 0.
  - last_grant <= w (updated in both modes).
- When load_en is set and no group is pending: out_valid <= 0; out_data and out_group hold their values.
- Stall: out_valid & ~out_ready freezes out_valid, out_data, out_group and all hold registers. Captures into empty registers continue during a stall.
- Latency: a word captured at edge N appears on out_data after edge N+1, given it wins and the output is free.
- Each accepted word is delivered exactly once, with no loss or duplication.
- Words from one group are delivered in capture order.
- Mode changes take effect on the next grant decision. last_grant is kept across mode changes.
- Starvation bound in mode 1: a pending group is granted within DATA_GROUPS grants.
- Mode 0 gives no starvation guarantee.

Test Plan:
- Reset with in_valid=4'b1111 held -> in_ready=4'b1111, out_valid=0 and out_data=0 while resetn=0. The first grants after release in mode 1 follow group order 0,1,2,3.
- Mode 0, all four groups loaded in one cycle with data 0xA0..0xA3, out_ready=1 -> outputs 0xA3, 0xA2, 0xA1, 0xA0 on consecutive cycles with out_group 3,2,1,0.
- Mode 1, groups 0 and 2 continuously requesting, out_ready=1 -> out_group alternates 0,2,0,2; each group's in_ready toggles 1,0.
- out_ready=0 for 5 cycles with a word in output and all groups held -> out_data stable, in_ready=0 for those groups; the 4 words drain after release with none lost.
- resetn asserted while out_valid=1 and 3 groups are held -> out_valid=0 and in_ready all 1 immediately (asynchronous); no stale word appears after release.
- Mode switched from 0 to 1 with last_grant=3 and groups 0 and 3 pending -> the next grant is group 0.
